usb_feed_writer: RTL and testbench
==================================

Name: usb_feed_writer

Overview:
- USB-side initiator for the feed address space: converts a tagged halfword stream (video, sound L, sound R) into sequential cart/USB-bus write requests toward the mux/buffer path.
- Keeps one halfword offset counter per channel. Emits offset 0 exactly once at each frame start, so the buffer performs one triple-buffer swap per frame.
- Sits between the USB packet unpacker and the mux write port.

Parameters:
- VIDEO_FRAME_HW, 38400, halfwords per video frame (240x160x16bpp); maximum 65536 (frame slot 0x20000 bytes).
- SOUND_FRAME_HW, 8, halfwords per sound frame (slot 0x10 bytes); maximum 8.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  input halfword valid
- s_ready  out  1  writer can accept the input halfword
- s_data  in  16  halfword payload
- s_chan  in  2  channel: 0 video, 1 sound L, 2 sound R, 3 reserved
- s_sof  in  1  halfword is the first of a frame
- m_req  out  1  write request to mux
- m_ack  in  1  mux accepted the write
- m_addr  out  26  cart/USB-bus byte address
- m_wdata  out  16  write data
- m_from_usb  out  1  source tag to the mux; equals m_req
- frame_done  out  1  one-cycle pulse: a frame completed on a channel
- frame_chan  out  2  channel of the frame_done or err_short pulse
- err_short  out  1  one-cycle pulse: s_sof arrived before the previous frame on that channel completed
- err_chan  out  1  one-cycle pulse: s_chan == 3 received

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0, every channel in the "expect SOF" state.
- States:
  - IDLE: s_ready = 1.
  - On s_valid & s_ready, register data, channel and address; go to REQ. The halfword is consumed on this beat.
  - REQ: m_req = 1; m_addr and m_wdata are held stable; s_ready = 0.
  - On m_ack, advance that channel's counter, fire any pulses, and return to IDLE.
- Throughput: one write per two cycles minimum (IDLE accept, REQ ack in the same cycle as m_req). m_req asserts the cycle after acceptance.
- Address:
  - Video: 0x1000000 + (off << 1).
  - Sound L: 0x1E00000 + (off << 1).
  - Sound R: 0x1F00000 + (off << 1).
  - Bit 0 is always 0. Arithmetic is 26-bit unsigned with no carry into bits above the channel field.
- Counter:
  - s_sof with counter != 0: counter forced to 0 for this beat and err_short pulses; the beat is written at offset 0.
  - First beat after reset on a channel without s_sof: written at its offset and treated as a valid mid-frame beat.
  - Ack at off == FRAME_HW-1: counter wraps to 0 and frame_done pulses with frame_chan.
  - frame_chan is held until the next pulse.
- Reserved channel (s_chan == 3): beat is accepted and dropped, no request is issued, err_chan pulses, state stays IDLE.
- Simultaneous frame_done and err_short are impossible: they come from different beats.
- rst during REQ: m_req drops the next cycle and the in-flight write is abandoned. The mux must tolerate a dropped request.
- m_ack outside REQ is ignored.

Optional Feature:
- Macro: USB_FEED_WRITER_STATS_EN.
- When defined:
  - Adds outputs stat_frames_v, stat_frames_l, stat_frames_r (16-bit each, wrapping) that increment on frame_done for the matching channel.
  - Adds stat_short (16-bit, saturating) that increments on err_short.
  - All counters clear on rst.
- When undefined: these ports and counters are absent and the remaining behaviour is identical.

Decomposition:
- Package gba_io_feed_pkg holds:
  - Channel typedef (FEED_CH_VIDEO, FEED_CH_SOUND_L, FEED_CH_SOUND_R, FEED_CH_RSVD).
  - Base-address constants for the three channels.
  - Frame slot-size constants.
  - The FSM state typedef.
- The buffer block imports the same address constants from this package.
- Sub-module feed_offset_counter, instantiated three times:
  - Inputs: clear, advance, frame_hw limit.
  - Outputs: offset, wrap pulse, nonzero flag.

Test Plan:
- Reset, then video beats with s_sof=1, data 0xA5A5, followed by 3 more beats → m_addr 0x1000000, 0x1000002, 0x1000004, 0x1000006; m_wdata matches each beat; m_req is one cycle after acceptance.
- Sound L, 8 beats with SOF on the first and m_ack tied high → addresses 0x1E00000 through 0x1E0000E, then frame_done=1 with frame_chan=1 on the 8th ack; the 9th beat (no SOF) goes to 0x1E00000.
- Interleaved V/L/R beats → each channel's offsets advance independently; the R address sequence is 0x1F00000, 0x1F00002.
- Video: 100 beats, then s_sof → err_short pulses and the SOF beat goes to 0x1000000; frame_done does not pulse.
- m_ack held low for 10 cycles → m_req, m_addr and m_wdata stay stable and s_ready stays 0. Assert rst mid-REQ → m_req=0 the next cycle and all counters return to 0.
- s_chan=3 → err_chan pulses, no m_req, and s_ready returns high the next cycle.

Source files
------------

// File: rtl/gba_io_feed_pkg.sv
// Shared definitions for the feed address space: channel codes, slot base addresses, slot sizes
// and the USB writer FSM state type.
package gba_io_feed_pkg;

    typedef enum logic [1:0] {
        FEED_CH_VIDEO   = 2'd0,
        FEED_CH_SOUND_L = 2'd1,
        FEED_CH_SOUND_R = 2'd2,
        FEED_CH_RSVD    = 2'd3
    } feed_ch_e;

    localparam logic [25:0] FEED_BASE_VIDEO   = 26'h100_0000;
    localparam logic [25:0] FEED_BASE_SOUND_L = 26'h1E0_0000;
    localparam logic [25:0] FEED_BASE_SOUND_R = 26'h1F0_0000;

    localparam int FEED_VIDEO_SLOT_BYTES = 'h2_0000;
    localparam int FEED_SOUND_SLOT_BYTES = 'h10;

    typedef enum logic {
        FEED_IDLE = 1'b0,
        FEED_REQ  = 1'b1
    } feed_state_e;

    // Halfword offset becomes a byte offset; the slot sizes keep it clear of the channel field.
    function automatic logic [25:0] feed_addr(input feed_ch_e ch, input logic [15:0] off);
        logic [25:0] base;
        case (ch)
            FEED_CH_VIDEO:   base = FEED_BASE_VIDEO;
            FEED_CH_SOUND_L: base = FEED_BASE_SOUND_L;
            FEED_CH_SOUND_R: base = FEED_BASE_SOUND_R;
            default:         base = 26'd0;
        endcase
        return base + {9'd0, off, 1'b0};
    endfunction

endpackage

// File: rtl/feed_offset_counter.sv
// Per-channel halfword offset counter: cleared at frame start, advanced on each acknowledged
// write, wrapping at the frame length.
module feed_offset_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        advance,
    input  logic [16:0] frame_hw,
    output logic [15:0] offset,
    output logic        wrap,
    output logic        nonzero
);

    logic [15:0] off_q;

    assign offset  = off_q;
    assign nonzero = (off_q != 16'd0);
    assign wrap    = advance && ({1'b0, off_q} == (frame_hw - 17'd1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            off_q <= 16'd0;
        end else if (advance) begin
            off_q <= wrap ? 16'd0 : off_q + 16'd1;
        end
    end

endmodule

// File: rtl/usb_feed_writer.sv
// USB-side initiator: turns tagged halfwords into sequential feed-space write requests.
// Optional statistics counters are built when USB_FEED_WRITER_STATS_EN is defined.
module usb_feed_writer
    import gba_io_feed_pkg::*;
#(
    parameter int VIDEO_FRAME_HW = 38400,
    parameter int SOUND_FRAME_HW = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_data,
    input  logic [1:0]  s_chan,
    input  logic        s_sof,
    output logic        m_req,
    input  logic        m_ack,
    output logic [25:0] m_addr,
    output logic [15:0] m_wdata,
    output logic        m_from_usb,
    output logic        frame_done,
    output logic [1:0]  frame_chan,
    output logic        err_short,
    output logic        err_chan
`ifdef USB_FEED_WRITER_STATS_EN
    ,
    output logic [15:0] stat_frames_v,
    output logic [15:0] stat_frames_l,
    output logic [15:0] stat_frames_r,
    output logic [15:0] stat_short
`endif
);

    localparam logic [16:0] VID_LIM = 17'(VIDEO_FRAME_HW);
    localparam logic [16:0] SND_LIM = 17'(SOUND_FRAME_HW);

    feed_state_e state_q, state_d;
    feed_ch_e    chan_q, chan_d;
    logic [25:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        short_q, short_d;
    logic        frame_done_q, frame_done_d;
    logic        err_short_q, err_short_d;
    logic        err_chan_q, err_chan_d;
    logic [1:0]  frame_chan_q, frame_chan_d;

    logic        accept, ack;
    logic [15:0] chOff [3];
    logic [3:0]  chWrap, chNz, chClear, chAdvance;
    logic [15:0] curOff;
    logic        curNz;

    assign accept = (state_q == FEED_IDLE) && s_valid && !rst;
    assign ack    = (state_q == FEED_REQ) && m_ack;

    for (genvar g = 0; g < 3; g++) begin : g_ctr
        assign chClear[g]   = accept && s_sof && (s_chan == 2'(g));
        assign chAdvance[g] = ack && (chan_q == feed_ch_e'(g));

        feed_offset_counter u_ctr (
            .clk      (clk),
            .rst      (rst),
            .clear    (chClear[g]),
            .advance  (chAdvance[g]),
            .frame_hw ((g == 0) ? VID_LIM : SND_LIM),
            .offset   (chOff[g]),
            .wrap     (chWrap[g]),
            .nonzero  (chNz[g])
        );
    end
    assign chClear[3]   = 1'b0;
    assign chAdvance[3] = 1'b0;
    assign chWrap[3]    = 1'b0;
    assign chNz[3]      = 1'b0;

    always_comb begin
        curOff = 16'd0;
        case (feed_ch_e'(s_chan))
            FEED_CH_VIDEO:   curOff = chOff[0];
            FEED_CH_SOUND_L: curOff = chOff[1];
            FEED_CH_SOUND_R: curOff = chOff[2];
            default:         curOff = 16'd0;
        endcase
        curNz = chNz[s_chan];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FEED_IDLE;
            chan_q       <= FEED_CH_VIDEO;
            addr_q       <= 26'd0;
            wdata_q      <= 16'd0;
            short_q      <= 1'b0;
            frame_done_q <= 1'b0;
            err_short_q  <= 1'b0;
            err_chan_q   <= 1'b0;
            frame_chan_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            chan_q       <= chan_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            short_q      <= short_d;
            frame_done_q <= frame_done_d;
            err_short_q  <= err_short_d;
            err_chan_q   <= err_chan_d;
            frame_chan_q <= frame_chan_d;
        end
    end

    // An SOF beat always lands at offset 0; a short previous frame is remembered until the ack.
    always_comb begin
        state_d      = state_q;
        chan_d       = chan_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        short_d      = short_q;
        frame_done_d = 1'b0;
        err_short_d  = 1'b0;
        err_chan_d   = 1'b0;
        frame_chan_d = frame_chan_q;
        s_ready      = 1'b0;
        m_req        = 1'b0;
        case (state_q)
            FEED_IDLE: begin
                s_ready = !rst;
                if (accept) begin
                    if (feed_ch_e'(s_chan) == FEED_CH_RSVD) begin
                        err_chan_d = 1'b1;
                    end else begin
                        chan_d  = feed_ch_e'(s_chan);
                        wdata_d = s_data;
                        addr_d  = feed_addr(feed_ch_e'(s_chan), s_sof ? 16'd0 : curOff);
                        short_d = s_sof && curNz;
                        state_d = FEED_REQ;
                    end
                end
            end
            FEED_REQ: begin
                m_req = 1'b1;
                if (ack) begin
                    frame_done_d = chWrap[chan_q];
                    err_short_d  = short_q;
                    if (chWrap[chan_q] || short_q) begin
                        frame_chan_d = chan_q;
                    end
                    state_d = FEED_IDLE;
                end
            end
            default: state_d = FEED_IDLE;
        endcase
    end

    assign m_addr     = addr_q;
    assign m_wdata    = wdata_q;
    assign m_from_usb = m_req;
    assign frame_done = frame_done_q;
    assign frame_chan = frame_chan_q;
    assign err_short  = err_short_q;
    assign err_chan   = err_chan_q;

`ifdef USB_FEED_WRITER_STATS_EN
    logic [15:0] statV_q, statL_q, statR_q, statShort_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            statV_q     <= 16'd0;
            statL_q     <= 16'd0;
            statR_q     <= 16'd0;
            statShort_q <= 16'd0;
        end else begin
            if (frame_done_q && frame_chan_q == 2'd0) statV_q <= statV_q + 16'd1;
            if (frame_done_q && frame_chan_q == 2'd1) statL_q <= statL_q + 16'd1;
            if (frame_done_q && frame_chan_q == 2'd2) statR_q <= statR_q + 16'd1;
            if (err_short_q && statShort_q != 16'hFFFF) statShort_q <= statShort_q + 16'd1;
        end
    end

    assign stat_frames_v = statV_q;
    assign stat_frames_l = statL_q;
    assign stat_frames_r = statR_q;
    assign stat_short    = statShort_q;
`endif

endmodule

// File: tb/tb_usb_feed_writer.sv
// Self-checking bench for usb_feed_writer: vector table plus hand-written stall, reset and
// reserved-channel sequences, with a queue of expected writes.
module tb_usb_feed_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic [1:0]  s_chan;
    logic        s_sof;
    logic        m_req;
    logic        m_ack;
    logic [25:0] m_addr;
    logic [15:0] m_wdata;
    logic        m_from_usb;
    logic        frame_done;
    logic [1:0]  frame_chan;
    logic        err_short;
    logic        err_chan;
`ifdef USB_FEED_WRITER_STATS_EN
    logic [15:0] stat_frames_v, stat_frames_l, stat_frames_r, stat_short;
`endif

    typedef struct {
        logic [1:0]  chan;
        logic [15:0] data;
        logic        sof;
        int          ackWait;
        logic [25:0] expAddr;
        logic        expDone;
        logic        expShort;
    } vec_t;

    int compared = 0;
    int mismatched = 0;
    logic [1:0]  expFrameChan = 2'd0;
    logic [41:0] sbQueue [$];
    vec_t        vecs [18];

    usb_feed_writer dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_chan     (s_chan),
        .s_sof      (s_sof),
        .m_req      (m_req),
        .m_ack      (m_ack),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_from_usb (m_from_usb),
        .frame_done (frame_done),
        .frame_chan (frame_chan),
        .err_short  (err_short),
        .err_chan   (err_chan)
`ifdef USB_FEED_WRITER_STATS_EN
        ,
        .stat_frames_v (stat_frames_v),
        .stat_frames_l (stat_frames_l),
        .stat_frames_r (stat_frames_r),
        .stat_short    (stat_short)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkVec(input logic [1:0] ch, input logic [15:0] d, input logic sof,
                                   input int ackWait, input logic [25:0] a, input logic done,
                                   input logic shrt);
        vec_t v;
        v.chan = ch; v.data = d; v.sof = sof; v.ackWait = ackWait;
        v.expAddr = a; v.expDone = done; v.expShort = shrt;
        return v;
    endfunction

    // Entered and left just after a rising edge with the DUT idle.
    task automatic applyStimulus(input vec_t v);
        logic [41:0] expW;
        s_valid = 1'b1;
        s_chan  = v.chan;
        s_data  = v.data;
        s_sof   = v.sof;
        if (v.chan != 2'd3) sbQueue.push_back({v.expAddr, v.data});
        @(negedge clk);
        checkOutput("s_ready_idle", 32'(s_ready), 32'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        if (v.chan == 2'd3) begin
            @(negedge clk);
            checkOutput("rsvd_err_chan", 32'(err_chan), 32'd1);
            checkOutput("rsvd_no_req", 32'(m_req), 32'd0);
            checkOutput("rsvd_s_ready", 32'(s_ready), 32'd1);
            @(posedge clk); #1;
            return;
        end
        @(negedge clk);
        checkOutput("m_req_after_accept", 32'(m_req), 32'd1);
        checkOutput("m_from_usb", 32'(m_from_usb), 32'd1);
        checkOutput("s_ready_req", 32'(s_ready), 32'd0);
        if (sbQueue.size() == 0) begin
            checkOutput("scoreboard_empty", 32'd1, 32'd0);
            expW = 42'd0;
        end else begin
            expW = sbQueue.pop_front();
        end
        checkOutput("m_addr", 32'(m_addr), 32'(expW[41:16]));
        checkOutput("m_wdata", 32'(m_wdata), 32'(expW[15:0]));
        for (int k = 0; k < v.ackWait; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checkOutput("stall_m_req", 32'(m_req), 32'd1);
            checkOutput("stall_m_addr", 32'(m_addr), 32'(expW[41:16]));
            checkOutput("stall_m_wdata", 32'(m_wdata), 32'(expW[15:0]));
            checkOutput("stall_s_ready", 32'(s_ready), 32'd0);
        end
        m_ack = 1'b1;
        @(posedge clk); #1;
        m_ack = 1'b0;
        if (v.expDone || v.expShort) expFrameChan = v.chan;
        @(negedge clk);
        checkOutput("m_req_after_ack", 32'(m_req), 32'd0);
        checkOutput("frame_done", 32'(frame_done), 32'(v.expDone));
        checkOutput("err_short", 32'(err_short), 32'(v.expShort));
        checkOutput("err_chan_quiet", 32'(err_chan), 32'd0);
        checkOutput("frame_chan", 32'(frame_chan), 32'(expFrameChan));
        @(posedge clk); #1;
    endtask

    initial begin
        vecs[0]  = mkVec(2'd0, 16'hA5A5, 1'b1, 0, 26'h100_0000, 1'b0, 1'b0);
        vecs[1]  = mkVec(2'd0, 16'h0001, 1'b0, 0, 26'h100_0002, 1'b0, 1'b0);
        vecs[2]  = mkVec(2'd0, 16'h0002, 1'b0, 1, 26'h100_0004, 1'b0, 1'b0);
        vecs[3]  = mkVec(2'd0, 16'h0003, 1'b0, 0, 26'h100_0006, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            vecs[4 + i] = mkVec(2'd1, 16'h1100 + 16'(i), (i == 0), 0,
                                26'h1E0_0000 + 26'(2 * i), (i == 7), 1'b0);
        vecs[12] = mkVec(2'd1, 16'h1200, 1'b0, 0, 26'h1E0_0000, 1'b0, 1'b0);
        vecs[13] = mkVec(2'd2, 16'h2000, 1'b1, 0, 26'h1F0_0000, 1'b0, 1'b0);
        vecs[14] = mkVec(2'd0, 16'h0004, 1'b0, 0, 26'h100_0008, 1'b0, 1'b0);
        vecs[15] = mkVec(2'd1, 16'h1201, 1'b0, 0, 26'h1E0_0002, 1'b0, 1'b0);
        vecs[16] = mkVec(2'd2, 16'h2001, 1'b0, 0, 26'h1F0_0002, 1'b0, 1'b0);
        vecs[17] = mkVec(2'd3, 16'hDEAD, 1'b0, 0, 26'h0, 1'b0, 1'b0);

        rst = 1'b1; s_valid = 1'b0; s_data = 16'h0; s_chan = 2'd0; s_sof = 1'b0; m_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_s_ready", 32'(s_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_m_req", 32'(m_req), 32'd0);
        checkOutput("rst_m_addr", 32'(m_addr), 32'd0);
        checkOutput("rst_m_wdata", 32'(m_wdata), 32'd0);
        checkOutput("rst_pulses", {29'd0, frame_done, err_short, err_chan}, 32'd0);
        checkOutput("rst_frame_chan", 32'(frame_chan), 32'd0);
        checkOutput("idle_s_ready", 32'(s_ready), 32'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 18; i++) applyStimulus(vecs[i]);

        // Video has written offsets 0..4; run it up to 100 beats, then cut the frame short.
        for (int i = 5; i < 100; i++)
            applyStimulus(mkVec(2'd0, 16'(i), 1'b0, 0, 26'h100_0000 + 26'(2 * i), 1'b0, 1'b0));
        applyStimulus(mkVec(2'd0, 16'hBEEF, 1'b1, 0, 26'h100_0000, 1'b0, 1'b1));
        applyStimulus(mkVec(2'd0, 16'h5A5A, 1'b0, 10, 26'h100_0002, 1'b0, 1'b0));

        // A stray ack while idle must not move any counter.
        m_ack = 1'b1;
        @(posedge clk); #1;
        m_ack = 1'b0;
        @(negedge clk);
        checkOutput("idle_ack_no_req", 32'(m_req), 32'd0);
        @(posedge clk); #1;
        applyStimulus(mkVec(2'd0, 16'h0C0C, 1'b0, 0, 26'h100_0004, 1'b0, 1'b0));

`ifdef USB_FEED_WRITER_STATS_EN
        checkOutput("stat_frames_l", 32'(stat_frames_l), 32'd1);
        checkOutput("stat_short", 32'(stat_short), 32'd1);
`endif

        // Reset while a request is outstanding.
        s_valid = 1'b1; s_chan = 2'd0; s_data = 16'h7777; s_sof = 1'b0;
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk);
        checkOutput("pre_rst_m_req", 32'(m_req), 32'd1);
        checkOutput("pre_rst_m_addr", 32'(m_addr), 32'h100_0006);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("rst_req_dropped", 32'(m_req), 32'd0);
        checkOutput("rst_addr_cleared", 32'(m_addr), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        expFrameChan = 2'd0;
        applyStimulus(mkVec(2'd0, 16'h0101, 1'b0, 0, 26'h100_0000, 1'b0, 1'b0));
        applyStimulus(mkVec(2'd1, 16'h0202, 1'b0, 0, 26'h1E0_0000, 1'b0, 1'b0));
        applyStimulus(mkVec(2'd2, 16'h0303, 1'b0, 0, 26'h1F0_0000, 1'b0, 1'b0));

        checkOutput("scoreboard_drained", 32'(sbQueue.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
